// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
//   uart_state_e    : serialiser state encoding (IDLE/START/DATA/PARITY/STOP)
//   UART_DATA_BITS  : data bits per frame
//   UART_IDLE_LEVEL : line level while no frame is in flight
//   clog2()         : ceiling log2 for sizing counters and pointers
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    UART_ST_IDLE   = 3'd0,
    UART_ST_START  = 3'd1,
    UART_ST_DATA   = 3'd2,
    UART_ST_PARITY = 3'd3,
    UART_ST_STOP   = 3'd4
  } uart_state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) result = 32'(i + 1);
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Bus-side signal bundle of the buffered UART transmitter.
//   writedata       : byte to queue
//   send_enable     : gates pushes
//   send_trigger    : push strobe
//   clear_overflow  : clears the sticky overflow flag
//   UART_TX         : serial line, idle high
//   send_work_state : FIFO non-empty or frame in flight
//   send_finish     : one-cycle pulse on the last stop-bit cycle
//   fifo_full       : byte queue full
//   overflow        : sticky dropped-push flag
// master: bus/CPU side. slave: the transmitter.
interface uart_tx_buffered_if;
  logic [7:0] writedata;
  logic       send_enable;
  logic       send_trigger;
  logic       clear_overflow;
  logic       UART_TX;
  logic       send_work_state;
  logic       send_finish;
  logic       fifo_full;
  logic       overflow;

  modport master (
    output writedata, send_enable, send_trigger, clear_overflow,
    input  UART_TX, send_work_state, send_finish, fifo_full, overflow
  );

  modport slave (
    input  writedata, send_enable, send_trigger, clear_overflow,
    output UART_TX, send_work_state, send_finish, fifo_full, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Pointer-based byte queue for the UART transmitter.
//   clk, rst_n : clock, synchronous active-low reset
//   push, pop  : write / read strobes (pop only honoured when non-empty)
//   clr_ovf    : clears overflow (a same-cycle drop wins)
//   wdata      : byte written on an accepted push
//   rdata_c    : head byte (combinational)
//   empty_c    : queue empty (combinational)
//   full       : queue holds DEPTH entries (registered)
//   overflow   : sticky, a push was dropped (registered)
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_ovf,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c,
  output logic             empty_c,
  output logic             full,
  output logic             overflow
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             do_push_c, do_pop_c, drop_c;

  assign empty_c = (wr_q == rd_q);
  assign rdata_c = mem_q[rd_q[AW-1:0]];

  // A push into a full queue survives only if the head leaves in the same cycle.
  always_comb begin
    do_pop_c  = pop && !empty_c;
    do_push_c = push && (!full_q || do_pop_c);
    drop_c    = push && full_q && !do_pop_c;
    wr_d      = do_push_c ? (wr_q + PW'(1)) : wr_q;
    rd_d      = do_pop_c ? (rd_q + PW'(1)) : rd_q;
    full_d    = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
    ovf_d     = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop_c)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_q[AW-1:0]] <= wdata;
  end

  assign full     = full_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: queues bus bytes and serialises them LSB first
// (8N1 by default) onto UART_TX.
//   sysclk : system clock, rising edge
//   reset  : synchronous active-low reset
//   bus    : uart_tx_buffered_if.slave (writedata, send_enable, send_trigger,
//            clear_overflow in; UART_TX, send_work_state, send_finish,
//            fifo_full, overflow out)
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit between the
// data bits and the stop bit.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic              sysclk,
  input logic              reset,
  uart_tx_buffered_if.slave bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned BAUD_W       = clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W        = 3;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

  uart_state_e                state_q, state_d;
  logic [BAUD_W-1:0]          baud_q, baud_d;
  logic [BIT_W-1:0]           bit_q, bit_d;
  logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
  logic                       tx_q, tx_d;
  logic                       finish_q, finish_d;
  logic                       work_q, work_d;
`ifdef UART_TX_PARITY_EN
  logic                       parity_q, parity_d;
`endif

  logic                       push_c, pop_c, bit_done_c;
  logic                       fifo_empty_c;
  logic [UART_DATA_BITS-1:0]  fifo_rdata_c;

  assign push_c = bus.send_trigger && bus.send_enable;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk      (sysclk),
    .rst_n    (reset),
    .push     (push_c),
    .pop      (pop_c),
    .clr_ovf  (bus.clear_overflow),
    .wdata    (bus.writedata),
    .rdata_c  (fifo_rdata_c),
    .empty_c  (fifo_empty_c),
    .full     (bus.fifo_full),
    .overflow (bus.overflow)
  );

  assign bit_done_c = (baud_q == BAUD_LAST);

  // Serialiser next state; the line level follows the registered state one
  // cycle later, which gives the pop-to-start-bit latency of two edges.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    finish_d = 1'b0;
    pop_c    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      UART_ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty_c) begin
          pop_c   = 1'b1;
          shift_d = fifo_rdata_c;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_rdata_c;
`endif
          state_d = UART_ST_START;
        end
      end
      UART_ST_START: begin
        if (bit_done_c) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = UART_ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      UART_ST_DATA: begin
        if (bit_done_c) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = UART_ST_PARITY;
`else
            state_d = UART_ST_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      UART_ST_PARITY: begin
        if (bit_done_c) begin
          baud_d  = '0;
          state_d = UART_ST_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      UART_ST_STOP: begin
        if (bit_done_c) begin
          baud_d   = '0;
          finish_d = 1'b1;
          state_d  = UART_ST_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        baud_d  = '0;
        state_d = UART_ST_IDLE;
      end
    endcase
  end

  // Registered line level and status derived from the current state.
  always_comb begin
    tx_d = UART_IDLE_LEVEL;
    case (state_q)
      UART_ST_START:  tx_d = 1'b0;
      UART_ST_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      UART_ST_PARITY: tx_d = parity_q;
`endif
      default:        tx_d = UART_IDLE_LEVEL;
    endcase
    work_d = (state_q != UART_ST_IDLE) || !fifo_empty_c;
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q  <= UART_ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= UART_IDLE_LEVEL;
      finish_q <= 1'b0;
      work_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      finish_q <= finish_d;
      work_q   <= work_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.UART_TX         = tx_q;
  assign bus.send_finish     = finish_q;
  assign bus.send_work_state = work_q;

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Transmit end of the CPU's serial port. Accepts bytes from the memory-mapped bus side, queues them in a small FIFO, and serialises them 8N1 (LSB first) onto UART_TX.
- Reports busy/finish status for the bus status register.
- Sits beside the receiver inside the UART peripheral wrapper and replaces the unbuffered sender.

Parameters:
- CLK_FREQ, 100000000: sysclk frequency in Hz.
- BAUD, 9600: line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated, must be >= 2.
- FIFO_DEPTH, 4: byte queue depth, power of two, >= 2.

Ports:
- sysclk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- writedata  in  8  byte to queue.
- send_enable  in  1  gates pushes; 0 ignores send_trigger.
- send_trigger  in  1  push strobe; each cycle with send_trigger=1 and send_enable=1 is one push.
- clear_overflow  in  1  clears overflow flag.
- UART_TX  out  1  serial line, idle high.
- send_work_state  out  1  1 while FIFO non-empty or a frame is in flight.
- send_finish  out  1  one-cycle pulse on the last cycle of each stop bit.
- fifo_full  out  1  FIFO holds FIFO_DEPTH bytes.
- overflow  out  1  sticky: a push was dropped.

Behaviour:
- Reset (reset=0 at an edge):
  - UART_TX=1, send_work_state=0, send_finish=0, fifo_full=0, overflow=0.
  - FIFO pointers zeroed, FSM to IDLE, baud counter 0.
  - Reset mid-frame aborts the frame; the line returns high at that edge.
- FIFO:
  - Push and pop pointers are log2(FIFO_DEPTH)+1 bits, wrapping naturally.
  - full = MSBs differ and LSBs equal; empty = pointers equal.
  - Push while full and no pop in the same cycle: byte dropped, overflow set.
  - Push and pop in the same cycle while full: accepted, count unchanged.
  - Push while empty: written to the FIFO. There is no bypass.
  - clear_overflow=1 clears overflow. If a drop happens in the same cycle, set wins.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
  - IDLE: if FIFO non-empty, pop the head into an 8-bit shift register, go to START, load baud counter 0.
  - START: UART_TX=0 for CLKS_PER_BIT cycles.
  - DATA: UART_TX=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit; 3-bit bit index goes 0..7; after bit 7 go to STOP.
  - STOP: UART_TX=1 for CLKS_PER_BIT cycles. send_finish=1 on the final cycle. Next state is IDLE.
  - IDLE may pop again on the cycle after STOP, so back-to-back frames have no extra idle bits beyond one sysclk.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Width is clog2(CLKS_PER_BIT).
- Latency: push accepted at edge N; FIFO visible at N+1; IDLE pops at N+1; UART_TX falls at edge N+2.
- Frame length: exactly 10*CLKS_PER_BIT cycles without parity.
- send_enable=0 blocks new pushes only. Queued and in-flight bytes still transmit.
- UART_TX, send_finish and fifo_full are registered outputs.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the FSM adds a PARITY state between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits, latched at pop) for CLKS_PER_BIT cycles. Frame length is 11*CLKS_PER_BIT.
- Undefined: there is no PARITY state and no parity logic; frame is 8N1.

Decomposition:
- Shared package uart_pkg:
  - state encoding typedef (IDLE/START/DATA/PARITY/STOP)
  - UART_DATA_BITS=8
  - UART_IDLE_LEVEL=1'b1
  - clog2 helper function
- The receiver reuses this package.
- Sub-module uart_tx_fifo: pointer-based byte FIFO with push/pop/full/empty/overflow. The serialiser FSM and baud counter stay in the top level.

Test Plan (CLK_FREQ=160, BAUD=10 → CLKS_PER_BIT=16):
- Single byte: reset, push 8'hA5 at edge 10 → UART_TX low from edge 12 for 16 cycles, then bits 1,0,1,0,0,1,0,1 (LSB first) at 16 cycles each, then high 16 cycles. send_finish pulses at edge 171. send_work_state falls at edge 172.
- Back-to-back: push 8'h00, 8'hFF, 8'h55 on consecutive cycles → three contiguous frames with a 1-cycle IDLE gap, three send_finish pulses 161 cycles apart, fifo_full never set.
- Overflow: with send_enable=1, push 6 bytes in 6 cycles (FIFO_DEPTH=4, first pops after 1 cycle) → 5 accepted, 6th dropped, overflow=1. clear_overflow pulse → overflow=0. Exactly 5 frames sent.
- Gate: send_enable=0, send_trigger pulses with 8'h3C → UART_TX stays high, send_work_state=0.
- Reset mid-frame: reset=0 during DATA bit 3 of 8'hC3 with 2 bytes queued → at next edge UART_TX=1, FIFO empty, no further frames or send_finish.
- With UART_TX_PARITY_EN: push 8'h07 → parity bit 1, stop bit follows, frame 176 cycles.
